// File: rtl/pipe_pkg.sv
// Shared definitions for the valid/ready pipeline latches: occupancy states,
// the bubble instruction word and payload widths of the standard stages.
package pipe_pkg;

  typedef enum logic [1:0] {
    PIPE_EMPTY = 2'd0,
    PIPE_ONE   = 2'd1,
    PIPE_TWO   = 2'd2
  } pipe_state_e;

  localparam logic [31:0] PIPE_NOP_IR = 32'h0000_0000;

  typedef enum logic [1:0] {
    STAGE_PC_IR  = 2'd0,
    STAGE_PC_A_B = 2'd1,
    STAGE_O_B    = 2'd2
  } pipe_stage_e;

  // Payload width an instantiating stage packs into DATA_W.
  function automatic int unsigned pipe_data_w(input pipe_stage_e stage);
    case (stage)
      STAGE_PC_IR:  return 32'd32;
      STAGE_PC_A_B: return 32'd96;
      STAGE_O_B:    return 32'd64;
      default:      return 32'd64;
    endcase
  endfunction

endpackage

// File: rtl/pipe_slot.sv
// One falling-edge pipeline entry; an empty slot always holds the NOP word and a
// zero payload so its outputs can drive the stage outputs directly.
module pipe_slot
  import pipe_pkg::*;
#(
  parameter int          DATA_W = 64,
  parameter logic [31:0] NOP_IR = PIPE_NOP_IR
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              clear,
  input  logic              load,
  input  logic [31:0]       load_ir,
  input  logic [DATA_W-1:0] load_data,
  output logic              valid,
  output logic [31:0]       ir,
  output logic [DATA_W-1:0] data
);

  // Entry register: clear wins over load.
  always_ff @(negedge clock or posedge reset) begin
    if (reset) begin
      valid <= 1'b0;
      ir    <= NOP_IR;
      data  <= '0;
    end else if (clear) begin
      valid <= 1'b0;
      ir    <= NOP_IR;
      data  <= '0;
    end else if (load) begin
      valid <= 1'b1;
      ir    <= load_ir;
      data  <= load_data;
    end else begin
      valid <= valid;
      ir    <= ir;
      data  <= data;
    end
  end

endmodule

// File: rtl/pipe_stage_latch.sv
// Valid/ready pipeline stage latch with optional two-entry skid buffer,
// flush-to-bubble and a saturating stall counter; state captures on falling edges.
module pipe_stage_latch
  import pipe_pkg::*;
#(
  parameter int          DATA_W  = 64,
  parameter bit          SKID_EN = 1'b1,
  parameter logic [31:0] NOP_IR  = PIPE_NOP_IR,
  parameter int          STALL_W = 16
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               flush,
  input  logic               in_valid,
  input  logic [31:0]        in_ir,
  input  logic [DATA_W-1:0]  in_data,
  output logic               in_ready,
  output logic               out_valid,
  output logic [31:0]        out_ir,
  output logic [DATA_W-1:0]  out_data,
  input  logic               out_ready,
  output logic [1:0]         occupancy,
  output logic [STALL_W-1:0] stall_count
);

  localparam logic [STALL_W-1:0] STALL_ONE = {{(STALL_W-1){1'b0}}, 1'b1};
  localparam logic [STALL_W-1:0] STALL_MAX = {STALL_W{1'b1}};

  logic              main_valid;
  logic              main_load;
  logic              main_clear;
  logic [31:0]       main_load_ir;
  logic [DATA_W-1:0] main_load_data;
  logic              skid_valid;
  logic [31:0]       skid_ir;
  logic [DATA_W-1:0] skid_data;
  logic              accept;
  pipe_state_e       state;

  assign accept = in_valid & in_ready;

  pipe_slot #(.DATA_W(DATA_W), .NOP_IR(NOP_IR)) u_main (
    .clock     (clock),
    .reset     (reset),
    .clear     (main_clear),
    .load      (main_load),
    .load_ir   (main_load_ir),
    .load_data (main_load_data),
    .valid     (main_valid),
    .ir        (out_ir),
    .data      (out_data)
  );

  generate
    if (SKID_EN) begin : g_skid
      logic skid_load;
      logic skid_clear;

      // A word arriving while main is held and not draining parks in skid.
      assign skid_load  = !flush & accept & main_valid & !out_ready;
      assign skid_clear = flush | (skid_valid & out_ready);
      assign in_ready   = !skid_valid;

      pipe_slot #(.DATA_W(DATA_W), .NOP_IR(NOP_IR)) u_skid (
        .clock     (clock),
        .reset     (reset),
        .clear     (skid_clear),
        .load      (skid_load),
        .load_ir   (in_ir),
        .load_data (in_data),
        .valid     (skid_valid),
        .ir        (skid_ir),
        .data      (skid_data)
      );
    end else begin : g_single
      assign skid_valid = 1'b0;
      assign skid_ir    = NOP_IR;
      assign skid_data  = '0;
      assign in_ready   = !main_valid | out_ready;
    end
  endgenerate

  // Main entry refill: from skid when it holds the older word, else from input.
  always_comb begin
    main_load      = 1'b0;
    main_load_ir   = in_ir;
    main_load_data = in_data;
    if (flush) begin
      main_load = 1'b0;
    end else if (skid_valid) begin
      main_load      = out_ready;
      main_load_ir   = skid_ir;
      main_load_data = skid_data;
    end else begin
      main_load = accept & (!main_valid | out_ready);
    end
    main_clear = flush | (main_valid & out_ready & !main_load);
  end

  // Occupancy decode from the slot valid bits.
  always_comb begin
    if (skid_valid) begin
      state = PIPE_TWO;
    end else if (main_valid) begin
      state = PIPE_ONE;
    end else begin
      state = PIPE_EMPTY;
    end
    case (state)
      PIPE_EMPTY: occupancy = 2'd0;
      PIPE_ONE:   occupancy = 2'd1;
      PIPE_TWO:   occupancy = 2'd2;
      default:    occupancy = 2'd0;
    endcase
  end

  assign out_valid = main_valid;

  // Blocked-input counter; a flush edge kills the blocked word, so it is not counted.
  always_ff @(negedge clock or posedge reset) begin
    if (reset) begin
      stall_count <= '0;
    end else if (in_valid & !in_ready & !flush & (stall_count != STALL_MAX)) begin
      stall_count <= stall_count + STALL_ONE;
    end else begin
      stall_count <= stall_count;
    end
  end

endmodule

// File: tb/tb_pipe_stage_latch.sv
// Self-checking bench: a skid instance and a single-entry instance share the
// stimulus; both are compared against a queue model, plus directed vectors.
module tb_pipe_stage_latch;
  import pipe_pkg::*;

  localparam int DW  = 64;
  localparam int SW0 = 3;

  logic          clock = 1'b1;
  logic          reset, flush, in_valid, out_ready;
  logic [31:0]   in_ir;
  logic [DW-1:0] in_data;

  logic          in_ready1, out_valid1, in_ready0, out_valid0;
  logic [31:0]   out_ir1, out_ir0;
  logic [DW-1:0] out_data1, out_data0;
  logic [1:0]    occ1, occ0;
  logic [15:0]   stall1;
  logic [SW0-1:0] stall0;

  pipe_stage_latch #(.DATA_W(DW), .SKID_EN(1'b1), .NOP_IR(PIPE_NOP_IR), .STALL_W(16)) dut (
    .clock(clock), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ir(in_ir),
    .in_data(in_data), .in_ready(in_ready1), .out_valid(out_valid1), .out_ir(out_ir1),
    .out_data(out_data1), .out_ready(out_ready), .occupancy(occ1), .stall_count(stall1));

  pipe_stage_latch #(.DATA_W(DW), .SKID_EN(1'b0), .NOP_IR(PIPE_NOP_IR), .STALL_W(SW0)) dut0 (
    .clock(clock), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ir(in_ir),
    .in_data(in_data), .in_ready(in_ready0), .out_valid(out_valid0), .out_ir(out_ir0),
    .out_data(out_data0), .out_ready(out_ready), .occupancy(occ0), .stall_count(stall0));

  always #5 clock = ~clock;

  typedef struct { logic [31:0] ir; logic [63:0] data; } ent_t;
  typedef struct {
    logic iv; logic [31:0] ir; logic ordy; logic fl;
    logic e_ov; logic [31:0] e_ir; logic [1:0] e_occ; logic e_rdy; logic [15:0] e_st;
  } vec_t;

  ent_t q1[$];
  ent_t q0[$];
  int unsigned s1, s0;
  int checks = 0;
  int failures = 0;
  vec_t tbl[17];

  function automatic logic [63:0] mk_data(input logic [31:0] ir);
    return {ir, ~ir};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    q1.delete();
    q0.delete();
    s1 = 0;
    s0 = 0;
  endtask

  // Compare both instances against the model state before the coming edge.
  task automatic compare_models();
    logic r1, r0;
    r1 = (q1.size() < 2);
    r0 = (q0.size() == 0) || out_ready;
    chk("skid in_ready", in_ready1, r1);
    chk("skid out_valid", out_valid1, q1.size() != 0);
    chk("skid out_ir", out_ir1, (q1.size() != 0) ? q1[0].ir : PIPE_NOP_IR);
    chk("skid out_data", out_data1, (q1.size() != 0) ? q1[0].data : 64'd0);
    chk("skid occupancy", occ1, q1.size());
    chk("skid stall_count", stall1, s1);
    chk("single in_ready", in_ready0, r0);
    chk("single out_valid", out_valid0, q0.size() != 0);
    chk("single out_ir", out_ir0, (q0.size() != 0) ? q0[0].ir : PIPE_NOP_IR);
    chk("single out_data", out_data0, (q0.size() != 0) ? q0[0].data : 64'd0);
    chk("single occupancy", occ0, q0.size());
    chk("single stall_count", stall0, s0);
  endtask

  // Transfer rules in queue form: drain the oldest, then append if there was room.
  task automatic model_edge();
    logic r1, r0;
    ent_t e;
    r1 = (q1.size() < 2);
    r0 = (q0.size() == 0) || out_ready;
    e.ir = in_ir;
    e.data = in_data;
    if (in_valid && !r1 && !flush && s1 < 32'hFFFF) s1++;
    if (in_valid && !r0 && !flush && s0 < (2**SW0 - 1)) s0++;
    if (flush) begin
      q1.delete();
      q0.delete();
    end else begin
      if (out_ready && q1.size() != 0) void'(q1.pop_front());
      if (in_valid && r1) q1.push_back(e);
      if (out_ready && q0.size() != 0) void'(q0.pop_front());
      if (in_valid && r0) q0.push_back(e);
    end
  endtask

  task automatic cycle(input logic iv, input logic [31:0] ir, input logic [63:0] d,
                       input logic ordy, input logic fl);
    in_valid  = iv;
    in_ir     = ir;
    in_data   = d;
    out_ready = ordy;
    flush     = fl;
    #1;
    compare_models();
    @(negedge clock);
    model_edge();
    @(posedge clock);
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    #1;
    reset = 1'b0;
    in_valid = 1'b0;
    flush = 1'b0;
    model_reset();
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_ir = 32'd0; in_data = '0;
    model_reset();

    tbl[0]  = '{1'b1, 32'h2880_0005, 1'b1, 1'b0, 1'b1, 32'h2880_0005, 2'd1, 1'b1, 16'd0};
    tbl[1]  = '{1'b1, 32'h1111_0001, 1'b1, 1'b0, 1'b1, 32'h1111_0001, 2'd1, 1'b1, 16'd0};
    tbl[2]  = '{1'b1, 32'h2222_0002, 1'b1, 1'b0, 1'b1, 32'h2222_0002, 2'd1, 1'b1, 16'd0};
    tbl[3]  = '{1'b1, 32'h3333_0003, 1'b1, 1'b0, 1'b1, 32'h3333_0003, 2'd1, 1'b1, 16'd0};
    tbl[4]  = '{1'b1, 32'h4444_0004, 1'b1, 1'b0, 1'b1, 32'h4444_0004, 2'd1, 1'b1, 16'd0};
    tbl[5]  = '{1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b0, 32'h0000_0000, 2'd0, 1'b1, 16'd0};
    tbl[6]  = '{1'b1, 32'hAAAA_000A, 1'b0, 1'b0, 1'b1, 32'hAAAA_000A, 2'd1, 1'b1, 16'd0};
    tbl[7]  = '{1'b1, 32'hBBBB_000B, 1'b0, 1'b0, 1'b1, 32'hAAAA_000A, 2'd2, 1'b0, 16'd0};
    tbl[8]  = '{1'b1, 32'hCCCC_000C, 1'b0, 1'b0, 1'b1, 32'hAAAA_000A, 2'd2, 1'b0, 16'd1};
    tbl[9]  = '{1'b1, 32'hCCCC_000C, 1'b0, 1'b0, 1'b1, 32'hAAAA_000A, 2'd2, 1'b0, 16'd2};
    tbl[10] = '{1'b1, 32'hCCCC_000C, 1'b0, 1'b0, 1'b1, 32'hAAAA_000A, 2'd2, 1'b0, 16'd3};
    tbl[11] = '{1'b1, 32'hCCCC_000C, 1'b1, 1'b0, 1'b1, 32'hBBBB_000B, 2'd1, 1'b1, 16'd4};
    tbl[12] = '{1'b1, 32'hCCCC_000C, 1'b1, 1'b0, 1'b1, 32'hCCCC_000C, 2'd1, 1'b1, 16'd4};
    tbl[13] = '{1'b0, 32'h0000_0000, 1'b0, 1'b0, 1'b1, 32'hCCCC_000C, 2'd1, 1'b1, 16'd4};
    tbl[14] = '{1'b1, 32'hDDDD_000D, 1'b0, 1'b0, 1'b1, 32'hCCCC_000C, 2'd2, 1'b0, 16'd4};
    tbl[15] = '{1'b1, 32'hEEEE_000E, 1'b0, 1'b1, 1'b0, 32'h0000_0000, 2'd0, 1'b1, 16'd4};
    tbl[16] = '{1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b0, 32'h0000_0000, 2'd0, 1'b1, 16'd4};

    // Reset state.
    @(posedge clock);
    #1;
    chk("reset out_valid", out_valid1, 1'b0);
    chk("reset out_ir", out_ir1, PIPE_NOP_IR);
    chk("reset out_data", out_data1, 64'd0);
    chk("reset occupancy", occ1, 2'd0);
    chk("reset stall_count", stall1, 16'd0);
    chk("reset in_ready", in_ready1, 1'b1);
    reset = 1'b0;
    @(posedge clock);

    // Directed vectors on the skid instance.
    for (int i = 0; i < 17; i++) begin
      cycle(tbl[i].iv, tbl[i].ir, mk_data(tbl[i].ir), tbl[i].ordy, tbl[i].fl);
      #1;
      chk($sformatf("tbl[%0d] out_valid", i), out_valid1, tbl[i].e_ov);
      chk($sformatf("tbl[%0d] out_ir", i), out_ir1, tbl[i].e_ir);
      chk($sformatf("tbl[%0d] out_data", i), out_data1, tbl[i].e_ov ? mk_data(tbl[i].e_ir) : 64'd0);
      chk($sformatf("tbl[%0d] occupancy", i), occ1, tbl[i].e_occ);
      chk($sformatf("tbl[%0d] in_ready", i), in_ready1, tbl[i].e_rdy);
      chk($sformatf("tbl[%0d] stall_count", i), stall1, tbl[i].e_st);
    end

    // Single-entry variant: combinational in_ready, no skid absorption.
    pulse_reset();
    cycle(1'b1, 32'h5555_0001, mk_data(32'h5555_0001), 1'b1, 1'b0);
    #1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    #1;
    chk("single in_ready ordy=1", in_ready0, 1'b1);
    out_ready = 1'b0;
    #1;
    chk("single in_ready ordy=0", in_ready0, 1'b0);
    chk("skid in_ready ordy=0", in_ready1, 1'b1);
    for (int i = 0; i < 10; i++)
      cycle(1'b1, 32'h6666_0000 + i, mk_data(32'h6666_0000 + i), 1'b0, 1'b0);
    #1;
    chk("single no absorb occupancy", occ0, 2'd1);
    chk("single held word", out_ir0, 32'h5555_0001);
    chk("single stall saturated", stall0, 3'd7);
    chk("skid occupancy two", occ1, 2'd2);
    chk("skid stall nine", stall1, 16'd9);

    // Asynchronous reset between edges.
    reset = 1'b1;
    #1;
    chk("async out_valid", out_valid1, 1'b0);
    chk("async out_ir", out_ir1, PIPE_NOP_IR);
    chk("async occupancy", occ1, 2'd0);
    chk("async stall_count", stall1, 16'd0);
    chk("async in_ready", in_ready1, 1'b1);
    chk("async single stall", stall0, 3'd0);
    reset = 1'b0;
    in_valid = 1'b0;
    model_reset();

    // Randomized traffic against the queue model.
    for (int i = 0; i < 400; i++) begin
      logic [31:0] r_ir;
      r_ir = $urandom;
      cycle($urandom_range(0, 3) != 0, r_ir, {$urandom, $urandom},
            $urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0);
    end
    #1;
    compare_models();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pipe_stage_latch.md
# pipe_stage_latch

Parametrised pipeline latch that replaces the fixed per-stage latches (IR/PC/operand registers with a bare write enable) with a valid/ready stage carrying a 32-bit instruction word plus a `DATA_W`-bit payload. It provides back-pressure through an optional two-entry skid buffer, flush-to-bubble, and NOP output when empty. It also keeps a saturating stall counter for performance debug. It sits between any two pipeline stages (F/D, D/X, X/M, M/W, and the multiply/divide writeback path). Stage-specific decoders hang off its `out_ir`.

## Interface
- `DATA_W`, 64: payload width (e.g. PC + A + B packed by the instantiating stage).
- `SKID_EN`, 1: 1 gives a two-entry skid buffer with a registered `in_ready`; 0 gives a single entry with a combinational `in_ready`.
- `NOP_IR`, 32'h0000_0000: instruction word presented while the stage holds no valid entry.
- `STALL_W`, 16: stall-counter width.
- `clock`  in  1  stage clock; all state captures on the falling edge.
- `reset`  in  1  asynchronous, active-high; clears all state immediately.
- `flush`  in  1  synchronous kill of all held entries.
- `in_valid`  in  1  upstream holds a valid instruction.
- `in_ir`  in  32  upstream instruction word.
- `in_data`  in  DATA_W  upstream payload.
- `in_ready`  out  1  stage accepts on the next capture edge.
- `out_valid`  out  1  stage presents a valid instruction.
- `out_ir`  out  32  held instruction, or `NOP_IR` when `out_valid`=0.
- `out_data`  out  DATA_W  held payload, or 0 when `out_valid`=0.
- `out_ready`  in  1  downstream consumes on the next capture edge.
- `occupancy`  out  2  number of held entries (0..2).
- `stall_count`  out  STALL_W  saturating count of blocked edges.

## Operation
- Transfers: the input side accepts on an edge with `in_valid & in_ready`. The output side drains on an edge with `out_valid & out_ready`.
- State machine (`SKID_EN`=1), with entries named main and skid:
  - EMPTY:
    - with `in_valid`, go to ONE.
    - otherwise stay in EMPTY.
  - ONE:
    - with `in_valid & out_ready`, stay in ONE; main is replaced by the new word.
    - with `in_valid & !out_ready`, go to TWO; the new word goes into skid.
    - with `!in_valid & out_ready`, go to EMPTY.
    - with neither, hold.
  - TWO:
    - with `out_ready`, go to ONE; skid moves into main.
    - otherwise hold.
  - `in_ready` = (state != TWO). It depends only on registered state, so there is no combinational path from `out_ready` to `in_ready`.
- `SKID_EN`=0:
  - Only the EMPTY and ONE states exist.
  - `in_ready` = `!out_valid | out_ready`, which is combinational.
- Output and occupancy:
  - `out_valid` = (state != EMPTY).
  - `out_ir`/`out_data` always come from main, or from `NOP_IR`/0 when EMPTY.
  - `occupancy` = 0, 1 or 2 for EMPTY, ONE or TWO.
- Flush:
  - The next state is EMPTY regardless of the handshakes.
  - Any input accepted on the same edge is discarded.
  - `stall_count` is unaffected.
- Stall counter:
  - Increments on every edge where `in_valid & !in_ready`.
  - Saturates at all-ones.
  - Cleared only by `reset`.
- Ordering: entries leave strictly in arrival order. Nothing is duplicated or dropped except by flush or reset.

## Timing
- Reset values: EMPTY, `out_valid`=0, `out_ir`=`NOP_IR`, `out_data`=0, `occupancy`=0, `stall_count`=0, `in_ready`=1.
- Reset asserted mid-operation clears state asynchronously, without waiting for an edge.
- Latency: a word accepted on falling edge n is visible on the outputs immediately after edge n. That is one edge, or zero cycles of extra bubble.
- Throughput: one word per cycle whenever `out_ready` is held at 1.
- When `out_ready` drops, one additional word is absorbed into skid before `in_ready` falls.
- When TWO and `out_ready`=1, the skid word appears on the output after that edge. `in_ready` rises at the same edge.
- Priority on any edge: `reset` > `flush` > handshakes.

## Structure
- Shared package `pipe_pkg`, containing:
  - the state enum {EMPTY, ONE, TWO};
  - `PIPE_NOP_IR` = 32'h0000_0000;
  - a helper giving the payload width for standard stages: PC+IR is 32, PC+A+B is 96, O+B is 64.
- Sub-module `pipe_slot`: one falling-edge register entry holding IR, payload and valid, with load and clear. It is instantiated twice when `SKID_EN`=1 and once otherwise.

## Test plan
- Reset, then `in_valid`=1, `in_ir`=32'h2880_0005, `out_ready`=1 → after one edge `out_valid`=1, `out_ir`=32'h2880_0005, `occupancy`=1.
- Stream 4 words with `out_ready`=1 throughout → the same 4 words emerge in order on consecutive edges with no bubbles; `stall_count`=0.
- Load A, B with `out_ready`=0, then keep `in_valid`=1:
  - `occupancy`=2 and `in_ready`=0;
  - `stall_count` rises by 1 per edge, e.g. 3 after 3 blocked edges;
  - raise `out_ready` → A, then B, then the pending word appear on successive edges.
- In state TWO, assert `flush` with `in_valid`=1 → next edge `out_valid`=0, `out_ir`=`NOP_IR`, `occupancy`=0, `in_ready`=1; `stall_count` is unchanged.
- With `SKID_EN`=0: `out_valid`=1 and `out_ready`=1 → `in_ready`=1 in the same cycle; `out_ready`=0 → `in_ready`=0; there is no skid absorption.
- Assert `reset` between edges while in TWO with `stall_count`=7 → all outputs return to reset values immediately; force `stall_count` to 16'hFFFF and block again → it stays at 16'hFFFF.
